// File: rtl/out_spike_buf_pkg.sv
// rtl/out_spike_buf_pkg.sv - shared packet layout and drain FSM encoding
// Packet layout (MSB..LSB): {src_x[3:0], src_y[3:0], neuron_id[id_w-1:0]}.
package out_spike_buf_pkg;

  localparam int PKT_COORD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  function automatic int pkt_width(input int id_w);
    return 2 * PKT_COORD_W + id_w;
  endfunction

  function automatic int pkt_y_lsb(input int id_w);
    return id_w;
  endfunction

  function automatic int pkt_x_lsb(input int id_w);
    return id_w + PKT_COORD_W;
  endfunction

endpackage

// File: rtl/out_spike_buf_prio_enc.sv
// rtl/out_spike_buf_prio_enc.sv - combinational lowest-set-bit finder
// Ports:
//   vec_i  in  N : request vector
//   idx_o  out W : index of the lowest set bit (0 when vec_i is empty)
//   any_o  out 1 : vec_i has at least one bit set
module spike_prio_enc #(
  parameter int N = 256,
  parameter int W = 8
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/out_spike_buf.sv
// rtl/out_spike_buf.sv - per-step fire-event collector and packet drainer
// Ports:
//   clk_i, rst_n_i          : clock, async active-low reset
//   spikeWrEn_i/Addr_i/_i   : neuron engine result strobe, index, fired flag
//   stepDone_i              : single-cycle end-of-step pulse
//   pkt_o/pkt_valid_o/pkt_ready_i : packet stream to the local router port
//   busy_o                  : drain in progress
//   stepSent_o              : pulse when every packet of a step was accepted
//   spikeCnt_o              : packets sent in the last completed step
//   overrun_o               : sticky, step end seen while still draining
module out_spike_buf
  import out_spike_buf_pkg::*;
#(
  parameter int NUM_NEURONS          = 256,
  parameter int NEURON_CNT_BIT_WIDTH = 8,
  parameter int SRC_X                = 0,
  parameter int SRC_Y                = 0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic                                         spikeWrEn_i,
  input  logic [NEURON_CNT_BIT_WIDTH-1:0]              spikeAddr_i,
  input  logic                                         spike_i,
  input  logic                                         stepDone_i,
  output logic [pkt_width(NEURON_CNT_BIT_WIDTH)-1:0]   pkt_o,
  output logic                                         pkt_valid_o,
  input  logic                                         pkt_ready_i,
  output logic                                         busy_o,
  output logic                                         stepSent_o,
  output logic [NEURON_CNT_BIT_WIDTH:0]                spikeCnt_o,
  output logic                                         overrun_o
);

  localparam int W  = NEURON_CNT_BIT_WIDTH;
  localparam int PW = pkt_width(W);
  localparam logic [PKT_COORD_W-1:0] SRC_X_C = PKT_COORD_W'(SRC_X);
  localparam logic [PKT_COORD_W-1:0] SRC_Y_C = PKT_COORD_W'(SRC_Y);

  logic [NUM_NEURONS-1:0] collect_q, collect_d;
  logic [NUM_NEURONS-1:0] send_q;
  logic [NUM_NEURONS-1:0] wr_vec;
  state_e                 state_q;
  logic [W:0]             cnt_q;
  logic [PW-1:0]          pkt_q;
  logic                   pkt_valid_q;
  logic                   busy_q;
  logic                   step_sent_q;
  logic [W:0]             spike_cnt_q;
  logic                   overrun_q;

  logic                   wr_ok;
  logic [W-1:0]           enc_idx;
  logic                   enc_any;
  logic                   step_accept;

  // Widen the address by one bit so NUM_NEURONS == 2**W still compares correctly.
  assign wr_ok = spikeWrEn_i && spike_i &&
                 ({1'b0, spikeAddr_i} < (W + 1)'(NUM_NEURONS));

  always_comb begin
    wr_vec = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      wr_vec[i] = wr_ok && (spikeAddr_i == W'(i));
    end
  end

  assign step_accept = (state_q == ST_IDLE) && stepDone_i;

  // The collect side never waits on the drain; it is only cleared when a step is handed over.
  always_comb begin
    collect_d = collect_q | wr_vec;
    if (step_accept) collect_d = '0;
  end

  // One encoder serves both SCAN and SEND: the bit being sent is already
  // cleared from send_q, so its output is always the next packet to load.
  spike_prio_enc #(
    .N(NUM_NEURONS),
    .W(W)
  ) u_prio_enc (
    .vec_i(send_q),
    .idx_o(enc_idx),
    .any_o(enc_any)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      collect_q <= '0;
    end else begin
      collect_q <= collect_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      send_q      <= '0;
      cnt_q       <= '0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      step_sent_q <= 1'b0;
      spike_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      step_sent_q <= 1'b0;
      if (stepDone_i && (state_q != ST_IDLE)) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (stepDone_i) begin
            // A write landing with the step-end pulse belongs to the finished step.
            send_q  <= collect_q | wr_vec;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!enc_any) begin
            busy_q      <= 1'b0;
            step_sent_q <= 1'b1;
            spike_cnt_q <= '0;
            state_q     <= ST_IDLE;
          end else begin
            pkt_q           <= {SRC_X_C, SRC_Y_C, enc_idx};
            send_q[enc_idx] <= 1'b0;
            pkt_valid_q     <= 1'b1;
            state_q         <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (pkt_ready_i) begin
            cnt_q <= cnt_q + (W + 1)'(1);
            if (enc_any) begin
              pkt_q           <= {SRC_X_C, SRC_Y_C, enc_idx};
              send_q[enc_idx] <= 1'b0;
            end else begin
              pkt_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              step_sent_q <= 1'b1;
              spike_cnt_q <= cnt_q + (W + 1)'(1);
              state_q     <= ST_IDLE;
            end
          end
        end

        default: begin
          pkt_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign pkt_o       = pkt_q;
  assign pkt_valid_o = pkt_valid_q;
  assign busy_o      = busy_q;
  assign stepSent_o  = step_sent_q;
  assign spikeCnt_o  = spike_cnt_q;
  assign overrun_o   = overrun_q;

endmodule
